sub_apb_arb: RTL and testbench

SUB_APB_ARB -- requirements
Module: sub_apb_arb

---
 rtl/sub_apb_pkg.sv | 22 ++
 rtl/sub_rr_arbiter.sv | 40 ++++
 rtl/sub_apb_arb.sv | 183 ++++++++++++++++++
 tb/tb_sub_apb_arb.sv | 347 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sub_apb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sub_apb_pkg
// Description : Shared types and default constants for the APB request
//               arbiter: FSM state encoding and default parameter values.
// Revision    : 1.0 - initial release
// ============================================================================
package sub_apb_pkg;

    localparam int C_NUM_REQ = 4;   // default number of requesters
    localparam int C_ADDR_W  = 8;   // default APB address width
    localparam int C_WIDTH   = 8;   // default APB data width
    localparam int C_TIMEOUT = 16;  // default ACCESS cycle limit

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/sub_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : sub_rr_arbiter
// Description : Combinational round-robin selector. Searches the request
//               mask starting at index ptr and wrapping around; returns the
//               first set request as a one-hot grant (all zero if none).
// Ports       : req_mask [NUM_REQ]  eligible requests
//               ptr      [PTR_W]    search start index (< NUM_REQ)
//               gnt      [NUM_REQ]  one-hot winner
// Revision    : 1.0 - initial release
// ============================================================================
module sub_rr_arbiter
    import sub_apb_pkg::*;
#(
    parameter int NUM_REQ = C_NUM_REQ,
    parameter int PTR_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_mask,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] gnt
);

    logic w_found;
    int   w_idx;

    always_comb begin
        gnt     = '0;
        w_found = 1'b0;
        w_idx   = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_idx = (int'(ptr) + i) % NUM_REQ;
            if (!w_found && req_mask[w_idx]) begin
                gnt[w_idx] = 1'b1;
                w_found    = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/sub_apb_arb.sv
`default_nettype none
// ============================================================================
// Module      : sub_apb_arb
// Description : Arbitrates NUM_REQ requesters onto one APB master port.
//               Round-robin winner is latched in IDLE, then a standard
//               SETUP/ACCESS transfer runs; the owner gets a one-cycle done
//               pulse carrying rdata/err.
// Ports       : clk, rst (async, active-low)
//               req/req_write/req_addr/req_wdata  requester side (packed)
//               gnt/done/rdata/err                requester responses
//               psel/penable/pwrite/paddr/pwdata  APB request
//               prdata/pready/pslverr             APB completer response
// Options     : SUB_APB_TIMEOUT_EN - end ACCESS with err=1 after TIMEOUT
//               cycles without pready.
// Revision    : 1.0 - initial release
// ============================================================================
module sub_apb_arb
    import sub_apb_pkg::*;
#(
    parameter int NUM_REQ = C_NUM_REQ,
    parameter int ADDR_W  = C_ADDR_W,
    parameter int WIDTH   = C_WIDTH,
    parameter int TIMEOUT = C_TIMEOUT
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ-1:0]        req_write,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*WIDTH-1:0]  req_wdata,
    output logic [NUM_REQ-1:0]        gnt,
    output logic [NUM_REQ-1:0]        done,
    output logic [WIDTH-1:0]          rdata,
    output logic                      err,
    output logic                      psel,
    output logic                      penable,
    output logic                      pwrite,
    output logic [ADDR_W-1:0]         paddr,
    output logic [WIDTH-1:0]          pwdata,
    input  logic [WIDTH-1:0]          prdata,
    input  logic                      pready,
    input  logic                      pslverr
);

    localparam int PTR_W = $clog2(NUM_REQ);

    state_t               state_q, state_d;
    logic [PTR_W-1:0]     ptr_q, ptr_d;
    logic [NUM_REQ-1:0]   gnt_q, gnt_d;
    logic [NUM_REQ-1:0]   done_q, done_d;
    logic [WIDTH-1:0]     rdata_q, rdata_d;
    logic                 err_q, err_d;
    logic                 pwrite_q, pwrite_d;
    logic [ADDR_W-1:0]    paddr_q, paddr_d;
    logic [WIDTH-1:0]     pwdata_q, pwdata_d;

    logic [NUM_REQ-1:0]   w_eligible;
    logic [NUM_REQ-1:0]   w_arb_gnt;

`ifdef SUB_APB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0]     cnt_q, cnt_d;
`else
    logic                 w_unused_timeout;
    assign w_unused_timeout = ^TIMEOUT;
`endif

    // The requester being acknowledged this cycle sits out one round so the
    // others can be arbitrated in the same cycle without it re-winning.
    assign w_eligible = req & ~done_q;

    sub_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_rr_arbiter (
        .req_mask (w_eligible),
        .ptr      (ptr_q),
        .gnt      (w_arb_gnt)
    );

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        gnt_d    = gnt_q;
        done_d   = '0;
        rdata_d  = '0;
        err_d    = 1'b0;
        pwrite_d = pwrite_q;
        paddr_d  = paddr_q;
        pwdata_d = pwdata_q;
`ifdef SUB_APB_TIMEOUT_EN
        cnt_d    = cnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (|w_arb_gnt) begin
                    state_d = ST_SETUP;
                    gnt_d   = w_arb_gnt;
                    for (int i = 0; i < NUM_REQ; i++) begin
                        if (w_arb_gnt[i]) begin
                            paddr_d  = req_addr[i*ADDR_W +: ADDR_W];
                            pwdata_d = req_wdata[i*WIDTH +: WIDTH];
                            pwrite_d = req_write[i];
                            ptr_d    = PTR_W'((i + 1) % NUM_REQ);
                        end
                    end
                end
            end
            ST_SETUP: begin
                state_d = ST_ACCESS;
`ifdef SUB_APB_TIMEOUT_EN
                cnt_d   = '0;
`endif
            end
            ST_ACCESS: begin
                if (pready) begin
                    state_d = ST_IDLE;
                    done_d  = gnt_q;
                    gnt_d   = '0;
                    err_d   = pslverr;
                    rdata_d = pwrite_q ? '0 : prdata;
                end
`ifdef SUB_APB_TIMEOUT_EN
                else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    state_d = ST_IDLE;
                    done_d  = gnt_q;
                    gnt_d   = '0;
                    err_d   = 1'b1;
                    rdata_d = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
`endif
            end
            default: begin
                state_d = ST_IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            ptr_q    <= '0;
            gnt_q    <= '0;
            done_q   <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
            pwrite_q <= 1'b0;
            paddr_q  <= '0;
            pwdata_q <= '0;
`ifdef SUB_APB_TIMEOUT_EN
            cnt_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            gnt_q    <= gnt_d;
            done_q   <= done_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
            pwrite_q <= pwrite_d;
            paddr_q  <= paddr_d;
            pwdata_q <= pwdata_d;
`ifdef SUB_APB_TIMEOUT_EN
            cnt_q    <= cnt_d;
`endif
        end
    end

    assign psel    = (state_q != ST_IDLE);
    assign penable = (state_q == ST_ACCESS);
    assign gnt     = gnt_q;
    assign done    = done_q;
    assign rdata   = rdata_q;
    assign err     = err_q;
    assign pwrite  = pwrite_q;
    assign paddr   = paddr_q;
    assign pwdata  = pwdata_q;

endmodule
`default_nettype wire

// File: tb/tb_sub_apb_arb.sv
`default_nettype none
// ============================================================================
// Module      : tb_sub_apb_arb
// Description : Directed self-checking bench for sub_apb_arb (4 requesters,
//               8-bit address and data). Honours SUB_APB_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sub_apb_arb;

    localparam int NUM_REQ = 4;
    localparam int ADDR_W  = 8;
    localparam int WIDTH   = 8;
    localparam int TIMEOUT = 16;

    logic                      clk = 1'b0;
    logic                      rst;
    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ-1:0]        req_write;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ*WIDTH-1:0]  req_wdata;
    logic [NUM_REQ-1:0]        gnt;
    logic [NUM_REQ-1:0]        done;
    logic [WIDTH-1:0]          rdata;
    logic                      err;
    logic                      psel;
    logic                      penable;
    logic                      pwrite;
    logic [ADDR_W-1:0]         paddr;
    logic [WIDTH-1:0]          pwdata;
    logic [WIDTH-1:0]          prdata;
    logic                      pready;
    logic                      pslverr;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    sub_apb_arb #(
        .NUM_REQ (NUM_REQ),
        .ADDR_W  (ADDR_W),
        .WIDTH   (WIDTH),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .gnt       (gnt),
        .done      (done),
        .rdata     (rdata),
        .err       (err),
        .psel      (psel),
        .penable   (penable),
        .pwrite    (pwrite),
        .paddr     (paddr),
        .pwdata    (pwdata),
        .prdata    (prdata),
        .pready    (pready),
        .pslverr   (pslverr)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst       = 1'b0;
        req       = '0;
        req_write = '0;
        req_addr  = '0;
        req_wdata = '0;
        prdata    = '0;
        pready    = 1'b0;
        pslverr   = 1'b0;
        tick();
        tick();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        rst = 1'b0;
        tick();
        checks++;
        if ({gnt, done, rdata, err, psel, penable, pwrite, paddr, pwdata} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got gnt=%h done=%h rdata=%h err=%b psel=%b penable=%b pwrite=%b paddr=%h pwdata=%h, want all 0",
                     gnt, done, rdata, err, psel, penable, pwrite, paddr, pwdata);
        end
        rst = 1'b1;
        tick();
        checks++;
        if ({psel, penable, gnt} !== 6'b0) begin
            errors++;
            $display("FAIL reset_idle: got psel=%b penable=%b gnt=%h, want 0 0 0", psel, penable, gnt);
        end
    endtask

    task automatic test_single_write();
        do_reset();
        req_write[0]    = 1'b1;
        req_addr[7:0]   = 8'h10;
        req_wdata[7:0]  = 8'hA5;
        pready          = 1'b1;
        req[0]          = 1'b1;
        tick();
        checks++;
        if ({psel, penable, pwrite, paddr, pwdata, gnt} !== {1'b1, 1'b0, 1'b1, 8'h10, 8'hA5, 4'b0001}) begin
            errors++;
            $display("FAIL write_setup: got psel=%b penable=%b pwrite=%b paddr=%h pwdata=%h gnt=%h, want 1 0 1 10 a5 1",
                     psel, penable, pwrite, paddr, pwdata, gnt);
        end
        tick();
        checks++;
        if ({psel, penable, done} !== {1'b1, 1'b1, 4'b0000}) begin
            errors++;
            $display("FAIL write_access: got psel=%b penable=%b done=%h, want 1 1 0", psel, penable, done);
        end
        tick();
        checks++;
        if ({done, err, rdata, psel, penable, gnt} !== {4'b0001, 1'b0, 8'h00, 1'b0, 1'b0, 4'b0000}) begin
            errors++;
            $display("FAIL write_done: got done=%h err=%b rdata=%h psel=%b penable=%b gnt=%h, want 1 0 00 0 0 0",
                     done, err, rdata, psel, penable, gnt);
        end
        req[0] = 1'b0;
        pready = 1'b0;
        tick();
        checks++;
        if ({done, psel} !== 5'b0) begin
            errors++;
            $display("FAIL write_pulse: got done=%h psel=%b, want 0 0", done, psel);
        end
    endtask

    task automatic test_read_wait();
        do_reset();
        req_addr[23:16] = 8'h22;
        prdata          = 8'h3C;
        req[2]          = 1'b1;
        tick();
        checks++;
        if ({psel, penable, pwrite, paddr, gnt} !== {1'b1, 1'b0, 1'b0, 8'h22, 4'b0100}) begin
            errors++;
            $display("FAIL read_setup: got psel=%b penable=%b pwrite=%b paddr=%h gnt=%h, want 1 0 0 22 4",
                     psel, penable, pwrite, paddr, gnt);
        end
        // Owner withdraws and scribbles its payload; the bus must not care.
        req[2]          = 1'b0;
        req_addr[23:16] = 8'h99;
        for (int k = 1; k <= 4; k++) begin
            tick();
            checks++;
            if ({psel, penable, paddr, done} !== {1'b1, 1'b1, 8'h22, 4'b0000}) begin
                errors++;
                $display("FAIL read_wait%0d: got psel=%b penable=%b paddr=%h done=%h, want 1 1 22 0",
                         k, psel, penable, paddr, done);
            end
            if (k == 4) pready = 1'b1;
        end
        tick();
        checks++;
        if ({done, rdata, err, psel} !== {4'b0100, 8'h3C, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL read_done: got done=%h rdata=%h err=%b psel=%b, want 4 3c 0 0", done, rdata, err, psel);
        end
        pready = 1'b0;
        tick();
        checks++;
        if ({psel, done} !== 5'b0) begin
            errors++;
            $display("FAIL read_no_regrant: got psel=%b done=%h, want 0 0", psel, done);
        end
    endtask

    task automatic test_round_robin();
        int          exp_order [5];
        logic [3:0]  exp_oh;
        exp_order = '{0, 1, 2, 3, 0};
        do_reset();
        rst       = 1'b0;
        req       = 4'b1111;
        req_write = 4'b1111;
        req_addr  = {8'h43, 8'h42, 8'h41, 8'h40};
        pready    = 1'b1;
        tick();
        rst = 1'b1;
        for (int j = 0; j < 5; j++) begin
            exp_oh = 4'b0001 << exp_order[j];
            tick();
            checks++;
            if ({gnt, psel, penable, done, paddr} !== {exp_oh, 1'b1, 1'b0, 4'b0000, 8'(8'h40 + exp_order[j])}) begin
                errors++;
                $display("FAIL rr_setup%0d: got gnt=%h psel=%b penable=%b done=%h paddr=%h, want gnt=%h 1 0 0 paddr=%h",
                         j, gnt, psel, penable, done, paddr, exp_oh, 8'(8'h40 + exp_order[j]));
            end
            tick();
            checks++;
            if ({psel, penable} !== 2'b11) begin
                errors++;
                $display("FAIL rr_access%0d: got psel=%b penable=%b, want 1 1", j, psel, penable);
            end
            tick();
            checks++;
            if ({done, gnt, psel} !== {exp_oh, 4'b0000, 1'b0}) begin
                errors++;
                $display("FAIL rr_done%0d: got done=%h gnt=%h psel=%b, want done=%h 0 0", j, done, gnt, psel, exp_oh);
            end
            if (j == 4) req = '0;
        end
        tick();
        checks++;
        if (psel !== 1'b0) begin
            errors++;
            $display("FAIL rr_drain: got psel=%b, want 0", psel);
        end
    endtask

    task automatic test_slverr();
        do_reset();
        prdata  = 8'h5A;
        pready  = 1'b1;
        pslverr = 1'b1;
        req[1]  = 1'b1;
        tick();
        tick();
        tick();
        checks++;
        if ({done, err, rdata} !== {4'b0010, 1'b1, 8'h5A}) begin
            errors++;
            $display("FAIL slverr_done: got done=%h err=%b rdata=%h, want 2 1 5a", done, err, rdata);
        end
        req     = '0;
        pslverr = 1'b0;
        tick();
        checks++;
        if ({done, err} !== 5'b0) begin
            errors++;
            $display("FAIL slverr_clear: got done=%h err=%b, want 0 0", done, err);
        end
    endtask

    task automatic test_timeout();
        do_reset();
        prdata = 8'hEE;
        req[0] = 1'b1;
        tick();
        req[0] = 1'b0;
`ifdef SUB_APB_TIMEOUT_EN
        begin
            int n_access;
            n_access = 0;
            for (int c = 0; c < 40; c++) begin
                tick();
                if (done !== 4'b0000) break;
                if (psel && penable) n_access++;
            end
            checks++;
            if ({done, err, rdata} !== {4'b0001, 1'b1, 8'h00} || n_access != TIMEOUT) begin
                errors++;
                $display("FAIL timeout_done: got done=%h err=%b rdata=%h access_cycles=%0d, want 1 1 00 %0d",
                         done, err, rdata, n_access, TIMEOUT);
            end
        end
`else
        begin
            int bad;
            bad = 0;
            for (int c = 0; c < 100; c++) begin
                tick();
                if (done !== 4'b0000 || {psel, penable} !== 2'b11) bad++;
            end
            checks++;
            if (bad != 0) begin
                errors++;
                $display("FAIL no_timeout_wait: got %0d cycles with done or left ACCESS, want 0", bad);
            end
        end
`endif
        do_reset();
    endtask

    task automatic test_reset_mid();
        do_reset();
        req[1] = 1'b1;
        tick();
        tick();
        checks++;
        if ({psel, penable, gnt} !== {1'b1, 1'b1, 4'b0010}) begin
            errors++;
            $display("FAIL rstmid_access: got psel=%b penable=%b gnt=%h, want 1 1 2", psel, penable, gnt);
        end
        rst = 1'b0;
        #1;
        checks++;
        if ({gnt, done, rdata, err, psel, penable, pwrite, paddr, pwdata} !== '0) begin
            errors++;
            $display("FAIL rstmid_async: got gnt=%h done=%h psel=%b penable=%b paddr=%h, want all 0",
                     gnt, done, psel, penable, paddr);
        end
        req[1] = 1'b0;
        tick();
        checks++;
        if ({done, psel} !== 5'b0) begin
            errors++;
            $display("FAIL rstmid_nodone: got done=%h psel=%b, want 0 0", done, psel);
        end
        rst    = 1'b1;
        req    = 4'b1010;
        pready = 1'b1;
        tick();
        checks++;
        if ({gnt, psel} !== {4'b0010, 1'b1}) begin
            errors++;
            $display("FAIL rstmid_ptr: got gnt=%h psel=%b, want 2 1", gnt, psel);
        end
        tick();
        tick();
        checks++;
        if (done !== 4'b0010) begin
            errors++;
            $display("FAIL rstmid_resume: got done=%h, want 2", done);
        end
        req    = '0;
        pready = 1'b0;
        tick();
        tick();
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_read_wait();
        test_round_robin();
        test_slverr();
        test_timeout();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
